// File: rtl/reg_file_mp_if.sv
`timescale 1ns/1ps
// Write, read and clear-control bundle of the multi-port register file.
// Purely combinational wiring; read data is registered inside the file.
// No backpressure; busy tells the master that writes are being dropped.
interface reg_file_mp_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int NUM_RD         = 2
);
    logic                             wr_en;
    logic [REG_ADDR_WIDTH-1:0]        addr_rd;
    logic [REG_WIDTH-1:0]             data_rd;
    logic [NUM_RD*REG_ADDR_WIDTH-1:0] addr_rs;
    logic [NUM_RD*REG_WIDTH-1:0]      data_rs;
    logic                             clr_req;
    logic                             busy;
    logic                             clr_done;

    modport master (
        output wr_en, addr_rd, data_rd, addr_rs, clr_req,
        input  data_rs, busy, clr_done
    );

    modport slave (
        input  wr_en, addr_rd, data_rd, addr_rs, clr_req,
        output data_rs, busy, clr_done
    );
endinterface

// File: rtl/reg_file_mp.sv
`timescale 1ns/1ps
// Multi-read-port register file, x0 hard-wired to zero, with a run-time clear sequencer.
// Reads are registered (1 cycle); the clear takes NUM_REG-1 cycles plus a one-cycle done pulse.
// No backpressure: while busy, writes are dropped and every read port returns zero.
module reg_file_mp #(
    parameter int NUM_REG        = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int NUM_RD         = 2,
    parameter bit BYPASS         = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    reg_file_mp_if.slave rf
);
    localparam int AW = REG_ADDR_WIDTH;
    localparam int W  = REG_WIDTH;
    localparam logic [AW-1:0] LAST_PTR = AW'(NUM_REG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    clr_state_t          state_q;
    clr_state_t          state_nxt;
    logic [AW-1:0]       ptr_q;
    logic [W-1:0]        regs [NUM_REG];
    logic [NUM_RD*W-1:0] rs_q;
    logic [NUM_RD*W-1:0] rs_nxt;
    logic                busy;
    logic                clr_done;
    logic                wr_ok;

    // A write is honoured only outside the clear and never to x0.
    assign wr_ok = rf.wr_en && !busy && (rf.addr_rd != '0);

    // Clear FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Clear FSM next state: clr_req only matters in IDLE, so it is neither restarted nor queued.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (rf.clr_req) state_nxt = CLEAR;
            CLEAR:   if (ptr_q == LAST_PTR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear FSM outputs decoded from state, so reset drops busy without waiting for a clock.
    always_comb begin
        busy     = (state_q == CLEAR);
        clr_done = (state_q == DONE);
    end

    // Clear pointer starts at 1 (x0 is already zero) and stops at the last entry instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && rf.clr_req) begin
            ptr_q <= AW'(1);
        end else if (state_q == CLEAR && ptr_q != LAST_PTR) begin
            ptr_q <= ptr_q + AW'(1);
        end
    end

    // Storage array: clearing takes priority over (and suppresses) user writes; x0 is only ever reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
        end else if (busy) begin
            regs[ptr_q] <= '0;
        end else if (wr_ok) begin
            regs[rf.addr_rd] <= rf.data_rd;
        end
    end

    // Read-port selection: zero while busy or for x0, else optional forward of this cycle's write.
    always_comb begin
        rs_nxt = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!busy && rf.addr_rs[k*AW +: AW] != '0) begin
                if (BYPASS && wr_ok && rf.addr_rs[k*AW +: AW] == rf.addr_rd) begin
                    rs_nxt[k*W +: W] = rf.data_rd;
                end else begin
                    rs_nxt[k*W +: W] = regs[rf.addr_rs[k*AW +: AW]];
                end
            end
        end
    end

    // Read data register giving the one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs_q <= '0;
        end else begin
            rs_q <= rs_nxt;
        end
    end

    assign rf.data_rs  = rs_q;
    assign rf.busy     = busy;
    assign rf.clr_done = clr_done;
endmodule

// File: tb/tb_reg_file_mp.sv
`timescale 1ns/1ps
// Scoreboard bench: two 4-port 64-bit files (forwarding on / off) driven with identical stimulus.
// Expected read data, busy and clr_done come from an array model with a busy-cycle countdown.
// A negedge monitor pops one expectation per clock edge and compares both files.
module tb_reg_file_mp;
    localparam int AW   = 5;
    localparam int W    = 64;
    localparam int NR   = 4;
    localparam int NREG = 32;

    typedef struct packed {
        logic [NR-1:0][W-1:0] byp;
        logic [NR-1:0][W-1:0] nob;
        logic                 busy;
        logic                 done;
    } exp_t;

    logic clk;
    logic reset_n;

    reg_file_mp_if #(.REG_ADDR_WIDTH(AW), .REG_WIDTH(W), .NUM_RD(NR)) if_b ();
    reg_file_mp_if #(.REG_ADDR_WIDTH(AW), .REG_WIDTH(W), .NUM_RD(NR)) if_n ();

    reg_file_mp #(
        .NUM_REG(NREG), .REG_ADDR_WIDTH(AW), .REG_WIDTH(W), .NUM_RD(NR), .BYPASS(1'b1)
    ) u_byp (
        .clk(clk), .reset_n(reset_n), .rf(if_b)
    );

    reg_file_mp #(
        .NUM_REG(NREG), .REG_ADDR_WIDTH(AW), .REG_WIDTH(W), .NUM_RD(NR), .BYPASS(1'b0)
    ) u_nob (
        .clk(clk), .reset_n(reset_n), .rf(if_n)
    );

    // Reference model state
    logic [W-1:0] mregs [NREG];
    int           m_busy_left;
    bit           m_done;
    exp_t         q [$];
    exp_t         mon_e;

    int cmp_cnt = 0;
    int err_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge, checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("bypass file port%0d", k), if_b.data_rs[k*W +: W], mon_e.byp[k]);
                chk($sformatf("no-bypass file port%0d", k), if_n.data_rs[k*W +: W], mon_e.nob[k]);
            end
            chk("bypass file busy", W'(if_b.busy), W'(mon_e.busy));
            chk("no-bypass file busy", W'(if_n.busy), W'(mon_e.busy));
            chk("bypass file clr_done", W'(if_b.clr_done), W'(mon_e.done));
            chk("no-bypass file clr_done", W'(if_n.clr_done), W'(mon_e.done));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        m_busy_left = 0;
        m_done      = 1'b0;
    endfunction

    // One clock of stimulus; the model predicts the outputs after the coming edge.
    task automatic step(input bit we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic [NR*AW-1:0] ras, input bit clr);
        exp_t          e;
        bit            busy_now;
        logic [AW-1:0] a;
        if_b.wr_en = we;  if_b.addr_rd = wa; if_b.data_rd = wd; if_b.addr_rs = ras; if_b.clr_req = clr;
        if_n.wr_en = we;  if_n.addr_rd = wa; if_n.data_rd = wd; if_n.addr_rs = ras; if_n.clr_req = clr;
        e = '0;
        busy_now = (m_busy_left > 0);
        for (int k = 0; k < NR; k++) begin
            a = ras[k*AW +: AW];
            if (!busy_now && a != 0) begin
                e.byp[k] = mregs[a];
                e.nob[k] = mregs[a];
                if (we && a == wa) e.byp[k] = wd;
            end
        end
        if (we && !busy_now && wa != 0) mregs[wa] = wd;
        if (m_done) begin
            m_done = 1'b0;
        end else if (busy_now) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done = 1'b1;
        end else if (clr) begin
            // Nothing is observable while busy, so the whole file can be zeroed up front.
            m_busy_left = NREG - 1;
            for (int i = 0; i < NREG; i++) mregs[i] = '0;
        end
        e.busy = (m_busy_left > 0);
        e.done = m_done;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    // One-cycle reset pulse, asserted mid-cycle so the async path is exercised.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset busy immediate", W'(if_b.busy), '0);
        chk("reset clr_done immediate", W'(if_b.clr_done), '0);
        chk("reset data_rs immediate", if_b.data_rs[W-1:0] | if_b.data_rs[W +: W], '0);
        model_reset();
        @(posedge clk);
        #1;
        q.push_back('0);
        reset_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] ra();
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    function automatic logic [NR*AW-1:0] rand_ras();
        logic [NR*AW-1:0] r;
        for (int k = 0; k < NR; k++) r[k*AW +: AW] = ra();
        return r;
    endfunction

    function automatic logic [W-1:0] rd64();
        return {$urandom, $urandom};
    endfunction

    task automatic random_phase(input int n);
        logic [AW-1:0]    wa;
        logic [NR*AW-1:0] ras;
        for (int i = 0; i < n; i++) begin
            wa = ra();
            for (int k = 0; k < NR; k++)
                ras[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? wa : ra();
            step(($urandom_range(0, 3) != 0), wa, rd64(), ras, ($urandom_range(0, 63) == 0));
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < NREG / NR; i++)
            step(1'b0, '0, '0, {AW'(4*i+3), AW'(4*i+2), AW'(4*i+1), AW'(4*i)}, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        if_b.wr_en = 1'b0; if_b.addr_rd = '0; if_b.data_rd = '0; if_b.addr_rs = '0; if_b.clr_req = 1'b0;
        if_n.wr_en = 1'b0; if_n.addr_rd = '0; if_n.data_rd = '0; if_n.addr_rs = '0; if_n.clr_req = 1'b0;
        model_reset();
        do_reset();

        // Write x5 then read it on ports 0 and 1
        step(1'b1, 5'd5, 64'hDEADBEEF, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);
        step(1'b0, 5'd0, '0, {5'd9, 5'd1, 5'd5, 5'd5}, 1'b0);

        // Writes to x0 are dropped, including the same-cycle forward attempt
        step(1'b1, 5'd0, 64'h12345678, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);
        step(1'b0, 5'd0, '0, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);

        // Same-cycle write/read of x7: forwarded on one file, old value on the other
        step(1'b1, 5'd7, 64'h0BAD_F00D_CAFE_0007, {5'd0, 5'd0, 5'd0, 5'd0}, 1'b0);
        step(1'b1, 5'd7, 64'hA5A5A5A5, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b0);
        step(1'b0, 5'd0, '0, {5'd7, 5'd7, 5'd7, 5'd7}, 1'b0);

        // Four distinct 64-bit registers read concurrently
        step(1'b1, 5'd3,  64'h1111_2222_3333_4444, '0, 1'b0);
        step(1'b1, 5'd9,  64'h5555_6666_7777_8888, '0, 1'b0);
        step(1'b1, 5'd17, 64'h9999_AAAA_BBBB_CCCC, '0, 1'b0);
        step(1'b1, 5'd30, 64'hDDDD_EEEE_FFFF_0123, '0, 1'b0);
        step(1'b0, 5'd0, '0, {5'd30, 5'd17, 5'd9, 5'd3}, 1'b0);

        random_phase(300);

        // Fill with nonzero data, then clear with a simultaneous write; writes during the clear are lost
        for (int i = 1; i < NREG; i++)
            step(1'b1, AW'(i), rd64() | 64'h1, rand_ras(), 1'b0);
        step(1'b1, 5'd12, 64'hFEED_FACE_0000_0012, {5'd12, 5'd0, 5'd12, 5'd12}, 1'b1);
        for (int i = 0; i < NREG + 2; i++)
            step(1'b1, AW'($urandom_range(1, NREG - 1)), rd64() | 64'h1, rand_ras(),
                 ($urandom_range(0, 1) == 1));
        read_all();

        // Reset ten cycles into a clear
        for (int i = 1; i < NREG; i += 3)
            step(1'b1, AW'(i), rd64() | 64'h1, rand_ras(), 1'b0);
        step(1'b0, '0, '0, rand_ras(), 1'b1);
        for (int i = 0; i < 9; i++)
            step(1'b0, '0, '0, rand_ras(), 1'b0);
        do_reset();
        for (int i = 0; i < NREG + 4; i++)
            step(1'b0, '0, '0, rand_ras(), 1'b0);
        read_all();

        random_phase(200);

        step(1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", W'(q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
